// File: rtl/sw_debounce_if.sv
// Switch-side signal bundle for sw_debounce: raw pin in, clean level, edge pulses
// and bounce counter out.
interface sw_debounce_if;
    logic       sw_raw;
    logic       sw_level;
    logic       sw_rise;
    logic       sw_fall;
    logic [7:0] bounce_cnt;

    // master: board/testbench side, slave: the debouncer
    modport master (
        output sw_raw,
        input  sw_level,
        input  sw_rise,
        input  sw_fall,
        input  bounce_cnt
    );

    modport slave (
        input  sw_raw,
        output sw_level,
        output sw_rise,
        output sw_fall,
        output bounce_cnt
    );
endinterface

// File: rtl/sw_debounce.sv
// Synchronises and debounces a raw switch pin. Outputs a clean level, one-cycle
// rise/fall pulses and a saturating count of aborted transitions.
module sw_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 20,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic         clk,
    input  logic         rst,
    sw_debounce_if.slave sw_if
);
    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        ARM_HI    = 2'd1,
        STABLE_HI = 2'd2,
        ARM_LO    = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [7:0]       bcnt_q, bcnt_d;
    logic [7:0]       bcnt_inc;

    // sw_raw only ever reaches the FSM through the last sync stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], sw_if.sw_raw};
    end

    assign s        = sync_q[SYNC_STAGES-1];
    assign bcnt_inc = (bcnt_q == 8'hFF) ? bcnt_q : bcnt_q + 8'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            bcnt_q  <= bcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        bcnt_d  = bcnt_q;
        case (state_q)
            STABLE_LO: begin
                cnt_d = '0;
                if (s) begin
                    state_d = ARM_HI;
                    cnt_d   = CNT_ONE;
                end
            end
            ARM_HI: begin
                if (!s) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                    bcnt_d  = bcnt_inc;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STABLE_HI: begin
                cnt_d = '0;
                if (!s) begin
                    state_d = ARM_LO;
                    cnt_d   = CNT_ONE;
                end
            end
            ARM_LO: begin
                if (s) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                    bcnt_d  = bcnt_inc;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = STABLE_LO;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

    assign sw_if.sw_level   = level_q;
    assign sw_if.sw_rise    = rise_q;
    assign sw_if.sw_fall    = fall_q;
    assign sw_if.bounce_cnt = bcnt_q;
endmodule

// File: tb/tb_sw_debounce.sv
// Randomised and directed bench for sw_debounce against a run-length reference model.
module tb_sw_debounce;
    localparam int DC = 8;
    localparam int SS = 2;

    logic clk = 1'b0;
    logic rst;

    sw_debounce_if sw_if();

    always #5 clk = ~clk;

    sw_debounce #(
        .DEBOUNCE_CYCLES(DC),
        .CNT_W          (4),
        .SYNC_STAGES    (SS)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .sw_if(sw_if)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // model: raw delayed SS edges, then count consecutive samples that disagree with level
    bit mq[$];
    int m_level, m_run, m_bcnt;
    int m_rise, m_fall;

    int edge_no = 0;
    int rise_edge, fall_edge, rise_cnt, fall_cnt;
    int start, fstart, b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < SS; i++) mq.push_back(1'b0);
        m_level = 0; m_run = 0; m_bcnt = 0; m_rise = 0; m_fall = 0;
    endtask

    task automatic model_edge(input bit raw);
        bit s;
        mq.push_back(raw);
        s = mq.pop_front();
        m_rise = 0;
        m_fall = 0;
        if (int'(s) != m_level) begin
            m_run++;
            if (m_run == DC) begin
                m_level = int'(s);
                m_run   = 0;
                if (s) m_rise = 1; else m_fall = 1;
            end
        end else if (m_run > 0) begin
            m_run = 0;
            if (m_bcnt < 255) m_bcnt++;
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".level"}, 32'(sw_if.sw_level), m_level);
        chk({tag, ".rise"},  32'(sw_if.sw_rise),  m_rise);
        chk({tag, ".fall"},  32'(sw_if.sw_fall),  m_fall);
        chk({tag, ".bcnt"},  32'(sw_if.bounce_cnt), m_bcnt);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".level"}, 32'(sw_if.sw_level), 0);
        chk({tag, ".rise"},  32'(sw_if.sw_rise),  0);
        chk({tag, ".fall"},  32'(sw_if.sw_fall),  0);
        chk({tag, ".bcnt"},  32'(sw_if.bounce_cnt), 0);
    endtask

    // called at a negedge; returns at the next negedge
    task automatic step(input bit raw);
        sw_if.sw_raw = raw;
        @(posedge clk);
        edge_no++;
        model_edge(raw);
        #1;
        chk_model("step");
        if (sw_if.sw_rise === 1'b1) begin rise_edge = edge_no; rise_cnt++; end
        if (sw_if.sw_fall === 1'b1) begin fall_edge = edge_no; fall_cnt++; end
        @(negedge clk);
    endtask

    task automatic run(input bit raw, input int n);
        repeat (n) step(raw);
    endtask

    task automatic do_reset(input int cycles, input bit toggle);
        rst = 1'b1;
        #1;
        chk_zero("rst_async");
        repeat (cycles) begin
            if (toggle) sw_if.sw_raw = 1'($urandom);
            @(posedge clk);
            #1;
            chk_zero("rst_hold");
            @(negedge clk);
        end
        model_reset();
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit lvl;
        int len;
        rst = 1'b1;
        sw_if.sw_raw = 1'b0;
        model_reset();
        @(negedge clk);

        // 1: reset with toggling input, then quiet low
        do_reset(3, 1'b1);
        sw_if.sw_raw = 1'b0;
        run(1'b0, 50);

        // 2: clean press and release
        rise_cnt = 0; fall_cnt = 0; rise_edge = 0; fall_edge = 0;
        start = edge_no;
        run(1'b1, 30);
        chk("s2.rise_lat", rise_edge - start, 10);
        chk("s2.rise_cnt", rise_cnt, 1);
        chk("s2.fall_cnt", fall_cnt, 0);
        chk("s2.bcnt", 32'(sw_if.bounce_cnt), 0);
        fstart = edge_no;
        run(1'b0, 20);
        chk("s2.fall_lat", fall_edge - fstart, 10);

        // 3: DC-1 glitch rejected, DC pulse accepted
        run(1'b1, 7);
        run(1'b0, 20);
        chk("s3.glitch_bcnt", 32'(sw_if.bounce_cnt), 1);
        chk("s3.glitch_level", 32'(sw_if.sw_level), 0);
        rise_cnt = 0; fall_cnt = 0;
        start = edge_no;
        run(1'b1, 8);
        fstart = edge_no;
        run(1'b0, 20);
        chk("s3.rise_lat", rise_edge - start, 10);
        chk("s3.fall_lat", fall_edge - fstart, 10);
        chk("s3.rise_cnt", rise_cnt, 1);
        chk("s3.fall_cnt", fall_cnt, 1);
        chk("s3.bcnt", 32'(sw_if.bounce_cnt), 1);

        // 4: bouncy release
        run(1'b1, 20);
        fall_cnt = 0;
        b0 = int'(sw_if.bounce_cnt);
        run(1'b0, 3); run(1'b1, 2); run(1'b0, 1); run(1'b1, 4);
        fstart = edge_no;
        run(1'b0, 20);
        chk("s4.bdelta", 32'(sw_if.bounce_cnt) - b0, 2);
        chk("s4.fall_lat", fall_edge - fstart, 10);
        chk("s4.fall_cnt", fall_cnt, 1);

        // 5: saturation
        repeat (300) begin run(1'b1, 3); run(1'b0, 5); end
        chk("s5.sat", 32'(sw_if.bounce_cnt), 255);
        chk("s5.level", 32'(sw_if.sw_level), 0);
        repeat (5) begin run(1'b1, 3); run(1'b0, 5); end
        chk("s5.hold", 32'(sw_if.bounce_cnt), 255);

        // 6: reset in the middle of arming high, raw held high through it
        run(1'b1, 5);
        do_reset(2, 1'b0);
        rise_cnt = 0;
        start = edge_no;
        run(1'b1, 20);
        chk("s6.rise_lat", rise_edge - start, 10);
        chk("s6.rise_cnt", rise_cnt, 1);

        // 7: random run lengths around the boundary, occasional reset
        lvl = 1'b0;
        for (int i = 0; i < 200; i++) begin
            lvl = ~lvl;
            len = int'($urandom_range(1, 14));
            run(lvl, len);
            if ($urandom_range(0, 39) == 0) do_reset(int'($urandom_range(1, 3)), 1'b1);
        end
        run(1'b0, 20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sw_debounce.md
Name: sw_debounce

Overview:
Synchronises and debounces a raw board slide-switch or push-button input. Its clean level output drives the switch input of the LED blinker stage directly downstream. It also emits one-cycle rise/fall pulses and a saturating count of rejected bounces for board bring-up. Sits between the SW pin and any logic that consumes switch state.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable synchronised samples required to accept a new level (10 ms at 50 MHz); legal range 2..2^CNT_W-1
CNT_W, 20, width of the stability counter
SYNC_STAGES, 2, number of metastability flops on sw_raw; legal range 2..4

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
sw_raw  in  1  raw, asynchronous, bouncing switch pin
sw_level  out  1  debounced level; feeds the blinker's enable input
sw_rise  out  1  one-cycle pulse when sw_level goes 0->1
sw_fall  out  1  one-cycle pulse when sw_level goes 1->0
bounce_cnt  out  8  saturating count of aborted transitions

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high. While rst=1, all flops are held at their reset values regardless of clk.
- Reset values: sync chain all 0, state STABLE_LO, counter 0, sw_level=0, sw_rise=0, sw_fall=0, bounce_cnt=0.
- Sync chain: SYNC_STAGES flops in series. The last stage is `s`, which the FSM samples. sw_raw must never reach the FSM directly.
- FSM states and transitions (evaluated every edge):
  - STABLE_LO: if s=1, go to ARM_HI with cnt=1. Otherwise stay.
  - ARM_HI:
    - if s=0: go to STABLE_LO, cnt=0, bounce_cnt+1.
    - else if cnt==DEBOUNCE_CYCLES-1: go to STABLE_HI, sw_level<=1, sw_rise<=1, cnt=0.
    - else cnt+1.
  - STABLE_HI: if s=0, go to ARM_LO with cnt=1. Otherwise stay.
  - ARM_LO: mirror of ARM_HI with polarity swapped. Success goes to STABLE_LO with sw_level<=0 and sw_fall<=1. Abort goes to STABLE_HI with bounce_cnt+1.
- Pulses: sw_rise and sw_fall are registered and high for exactly one cycle. They are never high simultaneously and default to 0 on every other edge.
- Latency: number the first rising edge at which sw_raw is captured at its new value as edge 1. sw_level and its pulse update on edge SYNC_STAGES+DEBOUNCE_CYCLES, provided s is held for all DEBOUNCE_CYCLES FSM samples.
- Glitch boundary: a synchronised pulse of DEBOUNCE_CYCLES-1 samples is rejected and counted. A pulse of exactly DEBOUNCE_CYCLES samples is accepted.
- Abort and re-arm: after an abort, a fresh transition restarts the count from 1. There is no partial credit.
- bounce_cnt: 8-bit, saturates at 255 and never wraps. It is cleared only by rst.
- Counter width: cnt never exceeds DEBOUNCE_CYCLES-1, so there is no overflow.
- Reset mid-operation: reset in any state returns all outputs to reset values asynchronously. If sw_raw is held high across reset release, the block performs a normal debounced rise with an sw_rise pulse at the standard latency.
- States are one-hot or binary (implementer's choice). Unreachable encodings recover to STABLE_LO on the next edge.

Test Plan:
(All scenarios use DEBOUNCE_CYCLES=8, SYNC_STAGES=2, so latency is 10 edges.)
1. Assert rst for 3 cycles with sw_raw toggling -> sw_level=0, sw_rise=0, sw_fall=0, bounce_cnt=0 throughout. Deassert with sw_raw=0 -> no change for 50 cycles.
2. Clean press: sw_raw 0->1 before edge 1, held 30 cycles -> sw_level=1 from edge 10. sw_rise=1 for only the cycle after edge 10. sw_fall stays 0. bounce_cnt=0.
3. Boundary glitches from STABLE_LO:
   - sw_raw high for 7 cycles then low -> no level change, bounce_cnt=1.
   - Then high for exactly 8 cycles then low -> sw_level rises at edge 10.
   - The subsequent low held 20 cycles -> sw_level falls 10 edges after the drop, with one sw_fall pulse, and bounce_cnt stays 1.
4. Bouncy release from STABLE_HI: sw_raw pattern low3/high2/low1/high4, then low held 20 cycles -> bounce_cnt increments by 2. sw_level falls exactly 10 edges after the final low begins. Exactly one sw_fall pulse.
5. Saturation: 300 glitches of 3 high / 5 low cycles -> sw_level stays 0, bounce_cnt reaches 255 and holds 255.
6. Reset mid-ARM_HI: sw_raw high, assert rst at cycle 6 for 2 cycles with sw_raw still high -> outputs 0 immediately (asynchronously). After release, sw_level rises at edge 10 counted from the first post-reset edge, with one sw_rise pulse.
